// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, branch condition codes,
// flag bit positions and the fetch-unit FSM state type.
package cpu_pkg;

  localparam logic [3:0] OPC_B   = 4'b1100;
  localparam logic [3:0] OPC_BR  = 4'b1101;
  localparam logic [3:0] OPC_PCS = 4'b1110;
  localparam logic [3:0] OPC_HLT = 4'b1111;

  localparam logic [2:0] COND_NE  = 3'b000;
  localparam logic [2:0] COND_EQ  = 3'b001;
  localparam logic [2:0] COND_GT  = 3'b010;
  localparam logic [2:0] COND_LT  = 3'b011;
  localparam logic [2:0] COND_GE  = 3'b100;
  localparam logic [2:0] COND_LE  = 3'b101;
  localparam logic [2:0] COND_OV  = 3'b110;
  localparam logic [2:0] COND_UNC = 3'b111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_ISSUE  = 2'd1,
    S_HALTED = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: (cond, flags{Z,V,N}) -> taken.
// Ports: cond[2:0], flags[2:0] in; taken out. Purely combinational.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z, v, n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      COND_NE:  taken = ~z;
      COND_EQ:  taken = z;
      COND_GT:  taken = ~z & ~n;
      COND_LT:  taken = n;
      COND_GE:  taken = z | ~n;
      COND_LE:  taken = n | z;
      COND_OV:  taken = v;
      COND_UNC: taken = 1'b1;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over imem req/ack,
// issues instr/opc to decode with valid/ready, and resolves next PC.
// Ports: clk, rst (sync, active-high); imem_req/addr/ack/rdata;
// instr, opc, instr_valid, instr_ready; halt, BEn, Br, flags, br_reg;
// pc, pc_plus2, halted, fetch_err.
// Option: define IFU_TIMEOUT_EN to enable the imem_ack wait timeout.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic [3:0]        opc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              halt,
  input  logic              BEn,
  input  logic              Br,
  input  logic [2:0]        flags,
  input  logic [ADDR_W-1:0] br_reg,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus2,
  output logic              halted,
  output logic              fetch_err
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must fit the 8-bit wait counter");
  end

  ifu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] br_off;
  logic              taken;
  logic              accept;

`ifdef IFU_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;
`endif

  branch_cond u_cond (
    .cond  (instr_q[11:9]),
    .flags (flags),
    .taken (taken)
  );

  // 9-bit word offset, sign-extended first, then scaled to bytes
  assign br_off = {{(ADDR_W-9){instr_q[8]}}, instr_q[8:0]} << 1;

  assign pc_plus2    = pc_q + ADDR_W'(2);
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opc         = instr_q[15:12];
  assign imem_req    = (state_q == S_FETCH) && !rst;
  assign instr_valid = (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALTED);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef IFU_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_ISSUE;
        end
`ifdef IFU_TIMEOUT_EN
        else begin
          wait_d = wait_q + 8'd1;
          if (wait_d == TO_LIM) begin
            state_d = S_HALTED;
            err_d   = 1'b1;
          end
        end
`endif
      end
      S_ISSUE: begin
`ifdef IFU_TIMEOUT_EN
        wait_d = '0;
`endif
        if (accept) begin
          if (halt) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_FETCH;
            if (Br && taken)
              pc_d = br_reg;
            else if (BEn && taken)
              pc_d = pc_plus2 + br_off;
            else
              pc_d = pc_plus2;
          end
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

`ifdef IFU_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// Covers reset, sequential fetch, branches, halt, stalls, mid-reset.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [3:0]  opc;
  logic        instr_valid;
  logic        instr_ready;
  logic        halt, BEn, Br;
  logic [2:0]  flags;
  logic [15:0] br_reg;
  logic [15:0] pc, pc_plus2;
  logic        halted, fetch_err;

  logic        ack_en;
  logic [15:0] mem [0:4095];
  int          checks = 0;
  int          fails  = 0;
  int          accepts = 0;

  always #5 clk = ~clk;

  assign imem_ack   = ack_en;
  assign imem_rdata = mem[imem_addr[12:1]];

  always @(posedge clk)
    if (!rst && instr_valid && instr_ready) accepts <= accepts + 1;

  instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opc(opc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .halt(halt), .BEn(BEn), .Br(Br),
    .flags(flags), .br_reg(br_reg),
    .pc(pc), .pc_plus2(pc_plus2),
    .halted(halted), .fetch_err(fetch_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ack_en = 1'b1;
    rst = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_req: got %b exp 0", imem_req);
    end
    checks++;
    if (pc !== 16'h0000 || instr !== 16'h0000 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_regs: pc=%h instr=%h v=%b exp 0/0/0",
               pc, instr, instr_valid);
    end
    checks++;
    if (halted !== 1'b0 || fetch_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: halted=%b err=%b exp 0/0", halted, fetch_err);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      fails++;
      $display("FAIL reset_release: req=%b addr=%h exp 1/0000",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || pc !== 16'(2 * i) ||
          instr !== mem[i] || opc !== mem[i][15:12] ||
          pc_plus2 !== 16'(2 * i + 2)) begin
        fails++;
        $display("FAIL seq_issue%0d: v=%b pc=%h instr=%h opc=%h p2=%h exp pc=%h instr=%h",
                 i, instr_valid, pc, instr, opc, pc_plus2, 16'(2 * i), mem[i]);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 ||
          imem_addr !== 16'(2 * i + 2)) begin
        fails++;
        $display("FAIL seq_fetch%0d: v=%b req=%b addr=%h exp 0/1/%h",
                 i, instr_valid, imem_req, imem_addr, 16'(2 * i + 2));
      end
    end
  endtask

  task automatic test_branch();
    tick();
    checks++;
    if (opc !== OPC_BR || pc !== 16'h0006) begin
      fails++;
      $display("FAIL br_issue: opc=%h pc=%h exp %h/0006", opc, pc, OPC_BR);
    end
    Br = 1'b1; br_reg = 16'h0010;
    tick();
    Br = 1'b0;
    checks++;
    if (imem_addr !== 16'h0010) begin
      fails++;
      $display("FAIL br_to_10: got %h exp 0010", imem_addr);
    end
    tick();
    checks++;
    if (instr !== 16'hC3FC || opc !== OPC_B) begin
      fails++;
      $display("FAIL b_issue: instr=%h opc=%h exp C3FC/%h", instr, opc, OPC_B);
    end
    BEn = 1'b1; flags = 3'b100;
    tick();
    BEn = 1'b0; flags = 3'b000;
    checks++;
    if (imem_addr !== 16'h000A) begin
      fails++;
      $display("FAIL beq_taken: got %h exp 000A", imem_addr);
    end
    tick();
    Br = 1'b1; br_reg = 16'h0010;
    tick();
    Br = 1'b0;
    tick();
    BEn = 1'b1; flags = 3'b000;
    tick();
    BEn = 1'b0;
    checks++;
    if (imem_addr !== 16'h0012) begin
      fails++;
      $display("FAIL beq_not_taken: got %h exp 0012", imem_addr);
    end
    tick();
    Br = 1'b1; flags = 3'b100; br_reg = 16'h0100;
    tick();
    Br = 1'b0; flags = 3'b000;
    checks++;
    if (imem_addr !== 16'h0014) begin
      fails++;
      $display("FAIL brne_not_taken: got %h exp 0014", imem_addr);
    end
    tick();
    Br = 1'b1; br_reg = 16'h1234;
    tick();
    Br = 1'b0;
    checks++;
    if (imem_addr !== 16'h1234) begin
      fails++;
      $display("FAIL br_unc: got %h exp 1234", imem_addr);
    end
    tick();
    Br = 1'b1; BEn = 1'b1; br_reg = 16'h0100;
    tick();
    Br = 1'b0; BEn = 1'b0;
    checks++;
    if (imem_addr !== 16'h0100) begin
      fails++;
      $display("FAIL br_priority: got %h exp 0100", imem_addr);
    end
    tick();
    BEn = 1'b1; flags = 3'b000;
    tick();
    BEn = 1'b0;
    checks++;
    if (imem_addr !== 16'h0106) begin
      fails++;
      $display("FAIL bgt_taken: got %h exp 0106", imem_addr);
    end
    tick();
    BEn = 1'b1; flags = 3'b001;
    tick();
    BEn = 1'b0; flags = 3'b000;
    checks++;
    if (imem_addr !== 16'h0106) begin
      fails++;
      $display("FAIL blt_back: got %h exp 0106", imem_addr);
    end
    tick();
    BEn = 1'b1; flags = 3'b000;
    tick();
    BEn = 1'b0;
    checks++;
    if (imem_addr !== 16'h0108) begin
      fails++;
      $display("FAIL blt_not_taken: got %h exp 0108", imem_addr);
    end
    tick();
    Br = 1'b1; br_reg = 16'hFFFE;
    tick();
    Br = 1'b0;
    tick();
    checks++;
    if (pc !== 16'hFFFE || pc_plus2 !== 16'h0000) begin
      fails++;
      $display("FAIL pc_wrap: pc=%h p2=%h exp FFFE/0000", pc, pc_plus2);
    end
    tick();
    checks++;
    if (imem_addr !== 16'h0000) begin
      fails++;
      $display("FAIL wrap_fetch: got %h exp 0000", imem_addr);
    end
  endtask

  task automatic test_halt();
    mem[3] = 16'hF000;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      tick();
    end
    tick();
    checks++;
    if (opc !== OPC_HLT || pc !== 16'h0006) begin
      fails++;
      $display("FAIL hlt_issue: opc=%h pc=%h exp %h/0006", opc, pc, OPC_HLT);
    end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
        pc !== 16'h0006) begin
      fails++;
      $display("FAIL hlt_enter: h=%b req=%b v=%b pc=%h exp 1/0/0/0006",
               halted, imem_req, instr_valid, pc);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 16'h0006) begin
        fails++;
        $display("FAIL hlt_sticky%0d: h=%b req=%b pc=%h exp 1/0/0006",
                 k, halted, imem_req, pc);
      end
    end
    mem[3] = 16'hDE00;
  endtask

  task automatic test_stall();
    int acc0;
    ack_en = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
        fails++;
        $display("FAIL ack_wait%0d: req=%b addr=%h v=%b exp 1/0000/0",
                 k, imem_req, imem_addr, instr_valid);
      end
    end
    ack_en = 1'b1; instr_ready = 1'b0;
    tick();
    ack_en = 1'b0;
    acc0 = accepts;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'h1234 || pc !== 16'h0000) begin
        fails++;
        $display("FAIL stall%0d: v=%b instr=%h pc=%h exp 1/1234/0000",
                 k, instr_valid, instr, pc);
      end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (accepts - acc0 !== 1 || pc !== 16'h0002 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_accept: acc=%0d pc=%h v=%b exp 1/0002/0",
               accepts - acc0, pc, instr_valid);
    end
    tick();
    tick();
    checks++;
    if (accepts - acc0 !== 1 || imem_addr !== 16'h0002) begin
      fails++;
      $display("FAIL stall_once: acc=%0d addr=%h exp 1/0002",
               accepts - acc0, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    ack_en = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst_req: got %b exp 0", imem_req);
    end
    tick();
    checks++;
    if (pc !== 16'h0000 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst_state: pc=%h v=%b exp 0000/0", pc, instr_valid);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h1234 || pc !== 16'h0000) begin
      fails++;
      $display("FAIL mid_rst_restart: v=%b instr=%h pc=%h exp 1/1234/0000",
               instr_valid, instr, pc);
    end
  endtask

`ifdef IFU_TIMEOUT_EN
  task automatic test_timeout();
    ack_en = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    checks++;
    if (fetch_err !== 1'b0 || halted !== 1'b0) begin
      fails++;
      $display("FAIL to_early: err=%b h=%b exp 0/0", fetch_err, halted);
    end
    tick();
    checks++;
    if (fetch_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin
      fails++;
      $display("FAIL to_fire: err=%b h=%b req=%b exp 1/1/0",
               fetch_err, halted, imem_req);
    end
    do_reset();
    checks++;
    if (fetch_err !== 1'b0 || halted !== 1'b0 || imem_addr !== 16'h0000) begin
      fails++;
      $display("FAIL to_clear: err=%b h=%b addr=%h exp 0/0/0000",
               fetch_err, halted, imem_addr);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[0]     = 16'h1234;
    mem[1]     = 16'hE123;
    mem[2]     = 16'h3456;
    mem[3]     = 16'hDE00;
    mem[5]     = 16'hDE00;
    mem[8]     = 16'hC3FC;
    mem[9]     = 16'hD000;
    mem[10]    = 16'hDE00;
    mem[12'h91A] = 16'hCE02;
    mem[12'h080] = 16'hC402;
    mem[12'h083] = 16'hC7FF;
    mem[12'h084] = 16'hDE00;
    rst = 1'b1; ack_en = 1'b0; instr_ready = 1'b1;
    halt = 1'b0; BEn = 1'b0; Br = 1'b0;
    flags = 3'b000; br_reg = 16'h0000;
    test_reset();
    test_sequential();
    test_branch();
    test_halt();
    test_stall();
    test_reset_mid();
`ifdef IFU_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
